// File: rtl/rv32i_pkg.sv
// Shared types and constants for the simulation-control MMIO stage.
// Holds the end-of-test FSM state encoding and the word offsets of the
// registers inside the 16-byte MMIO window.
package rv32i_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } sim_state_e;

   // Register offsets within the window (byte offsets, word aligned)
   localparam logic [3:0] MMIO_TOHOST  = 4'h0;
   localparam logic [3:0] MMIO_CONSOLE = 4'h4;
   localparam logic [3:0] MMIO_STATUS  = 4'h8;
   localparam logic [3:0] MMIO_CYCLE   = 4'hC;

endpackage

// File: rtl/con_fifo.sv
// Synchronous console FIFO. DEPTH must be a power of two so the pointers
// wrap naturally. The head entry is read combinationally so the consumer
// sees the byte in the same cycle con_valid rises. A push into a full FIFO
// is still accepted when a pop happens in the same cycle.
module con_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign count   = count_reg;
   assign head    = mem_reg[rd_ptr_reg];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Storage write; contents need no reset because count guards every read
   always_ff @(posedge clk) begin
      if (do_push) mem_reg[wr_ptr_reg] <= push_data;
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
         else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
      end
   end

endmodule

// File: rtl/sim_mmio_ctrl.sv
// Data-bus MMIO stage between the CPU data port and simple_memory.
// Decodes a 16-byte simulation-control window (tohost, console, status,
// cycle counter), forwards everything else to memory, and runs a watchdog.
// Optional macro SIM_MMIO_PRINT_EN: echo console bytes and report the halt
// with system tasks (simulation only). Undefined: fully synthesizable.
module sim_mmio_ctrl
   import rv32i_pkg::*;
#(
   parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000,
   parameter int          FIFO_DEPTH   = 16,
   parameter int          MAX_CYCLES   = 200,
   parameter logic [31:0] TIMEOUT_CODE = 32'hDEAD_0001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_we,
   input  logic        data_re,
   output logic [31:0] data_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_we,
   output logic        mem_re,
   input  logic [31:0] mem_rdata,
   output logic        con_valid,
   output logic [7:0]  con_data,
   input  logic        con_ready,
   output logic        halt,
   output logic        timeout,
   output logic [31:0] halt_code
);

   sim_state_e state_reg, state_next;
   logic [31:0] halt_code_reg, halt_code_next;
   logic        timeout_reg, timeout_next;
   logic [31:0] cycle_cnt_reg;
   logic [15:0] ovf_cnt_reg;

   logic                         in_window;
   logic [3:0]                   offset;
   logic                         is_run;
   logic                         tohost_wr;
   logic                         con_wr;
   logic                         con_drop;
   logic                         wd_fire;
   logic                         fifo_push;
   logic                         fifo_pop;
   logic                         fifo_full;
   logic                         fifo_empty;
   logic [$clog2(FIFO_DEPTH):0]  fifo_count;
   logic [7:0]                   fifo_count8;

   assign in_window = (data_addr[31:4] == MMIO_BASE[31:4]);
   assign offset    = {data_addr[3:2], 2'b00};
   assign is_run    = (state_reg == RUN);

   assign tohost_wr = in_window && (offset == MMIO_TOHOST) && (|data_we) && (|data_wdata) && is_run;
   assign con_wr    = in_window && (offset == MMIO_CONSOLE) && data_we[0] && is_run;
   assign fifo_pop  = con_valid && con_ready;
   assign fifo_push = con_wr;
   assign con_drop  = con_wr && fifo_full && !fifo_pop;
   assign wd_fire   = (MAX_CYCLES != 0) && (state_reg != HALTED) &&
                      (cycle_cnt_reg == 32'(MAX_CYCLES - 1));

   assign mem_addr  = data_addr;
   assign mem_wdata = data_wdata;
   assign mem_we    = (!in_window && is_run) ? data_we : 4'b0000;
   assign mem_re    = !in_window ? data_re : 1'b0;

   assign con_valid   = !fifo_empty;
   assign fifo_count8 = 8'(fifo_count);
   assign halt        = (state_reg == HALTED);
   assign timeout     = timeout_reg;
   assign halt_code   = halt_code_reg;

   con_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_con_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (data_wdata[7:0]),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (con_data)
   );

   // Zero-latency read mux: window registers or memory pass-through
   always_comb begin
      data_rdata = mem_rdata;
      if (in_window) begin
         case (offset)
            MMIO_TOHOST: data_rdata = halt_code_reg;
            MMIO_STATUS: data_rdata = {ovf_cnt_reg, fifo_count8, 5'b0, timeout_reg, state_reg};
            MMIO_CYCLE:  data_rdata = cycle_cnt_reg;
            default:     data_rdata = 32'h0;
         endcase
      end
   end

   // End-of-test FSM next state; a tohost write beats a same-cycle watchdog
   always_comb begin
      state_next     = state_reg;
      halt_code_next = halt_code_reg;
      timeout_next   = timeout_reg;
      case (state_reg)
         RUN: begin
            if (tohost_wr) begin
               state_next     = DRAIN;
               halt_code_next = data_wdata;
            end else if (wd_fire) begin
               state_next     = HALTED;
               timeout_next   = 1'b1;
               halt_code_next = TIMEOUT_CODE;
            end
         end
         DRAIN: begin
            if (wd_fire) begin
               state_next     = HALTED;
               timeout_next   = 1'b1;
               halt_code_next = TIMEOUT_CODE;
            end else if (fifo_empty) begin
               state_next = HALTED;
            end
         end
         HALTED:  state_next = HALTED;
         default: state_next = RUN;
      endcase
   end

   // FSM and halt result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= RUN;
         halt_code_reg <= 32'h0;
         timeout_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         halt_code_reg <= halt_code_next;
         timeout_reg   <= timeout_next;
      end
   end

   // Cycle counter runs until halt, then freezes for post-mortem reads
   always_ff @(posedge clk) begin
      if (rst)                     cycle_cnt_reg <= 32'h0;
      else if (state_reg != HALTED) cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
   end

   // Saturating count of console bytes dropped on a full FIFO
   always_ff @(posedge clk) begin
      if (rst) ovf_cnt_reg <= 16'h0;
      else if (con_drop && ovf_cnt_reg != 16'hFFFF) ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
   end

`ifdef SIM_MMIO_PRINT_EN
   // Simulation console: echo each popped byte and announce entry to HALTED
   always @(posedge clk) begin
      if (!rst && fifo_pop) $write("%c", con_data);
      if (!rst && state_reg != HALTED && state_next == HALTED)
         $display("[sim_mmio_ctrl] halt_code=0x%08h timeout=%0d", halt_code_next, timeout_next);
   end
`else
   // Default build: no console echo; port behaviour is identical.
`endif

endmodule

// File: tb/tb_sim_mmio_ctrl.sv
// Self-checking bench for sim_mmio_ctrl: a table of single-cycle vectors for
// decode, pass-through and console basics, then hand-written sequences for
// FIFO overflow, drain-then-halt, watchdog, tohost/watchdog race and reset
// during drain.
module tb_sim_mmio_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [3:0]  data_we;
   logic        data_re;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_we;
   logic        mem_re;
   logic        con_valid, con_ready;
   logic [7:0]  con_data;
   logic        halt, timeout;
   logic [31:0] halt_code;

   int tests  = 0;
   int failed = 0;

   localparam logic [31:0] A_TOHOST  = 32'hFFFF_0000;
   localparam logic [31:0] A_CONSOLE = 32'hFFFF_0004;
   localparam logic [31:0] A_STATUS  = 32'hFFFF_0008;
   localparam logic [31:0] A_CYCLE   = 32'hFFFF_000C;

   sim_mmio_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_we    (data_we),
      .data_re    (data_re),
      .data_rdata (data_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_rdata  (mem_rdata),
      .con_valid  (con_valid),
      .con_data   (con_data),
      .con_ready  (con_ready),
      .halt       (halt),
      .timeout    (timeout),
      .halt_code  (halt_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  we;
      logic        re;
      logic        rdy;
      logic [31:0] mrd;
      logic [31:0] exp_rdata;
      logic [3:0]  exp_mem_we;
      logic        exp_mem_re;
      logic        exp_cv;
      logic [7:0]  exp_cd;
      logic        exp_halt;
   } vec_t;

   vec_t vecs [20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] we,
                        input logic re, input logic rdy, input logic [31:0] mrd);
      data_addr  = addr;
      data_wdata = wdata;
      data_we    = we;
      data_re    = re;
      con_ready  = rdy;
      mem_rdata  = mrd;
      #2;
   endtask

   task automatic idle(input logic rdy);
      drive(32'h0, 32'h0, 4'h0, 1'b0, rdy, 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      idle(1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      // idx: addr, wdata, we, re, rdy, mrd | rdata, mem_we, mem_re, con_valid, con_data, halt
      vecs[0]  = '{32'h0000_0100, 32'h0, 4'h0, 1, 0, 32'hCAFE_BABE, 32'hCAFE_BABE, 4'h0, 1, 0, 8'h00, 0};
      vecs[1]  = '{32'h0000_0104, 32'h1234_5678, 4'hF, 0, 0, 32'h0, 32'h0, 4'hF, 0, 0, 8'h00, 0};
      vecs[2]  = '{A_STATUS, 32'h0, 4'h0, 1, 0, 32'h5555, 32'h0, 4'h0, 0, 0, 8'h00, 0};
      vecs[3]  = '{A_CYCLE, 32'h0, 4'h0, 1, 0, 32'h0, 32'd3, 4'h0, 0, 0, 8'h00, 0};
      vecs[4]  = '{32'hFFFF_000F, 32'h0, 4'h0, 1, 0, 32'h0, 32'd4, 4'h0, 0, 0, 8'h00, 0};
      vecs[5]  = '{A_TOHOST, 32'h0, 4'h0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 8'h00, 0};
      vecs[6]  = '{A_STATUS, 32'hFFFF_FFFF, 4'hF, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 8'h00, 0};
      vecs[7]  = '{A_CONSOLE, 32'h48, 4'h1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 8'h00, 0};
      vecs[8]  = '{A_CONSOLE, 32'h69, 4'h1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 8'h48, 0};
      vecs[9]  = '{A_STATUS, 32'h0, 4'h0, 1, 0, 32'h0, 32'h0000_0200, 4'h0, 0, 1, 8'h48, 0};
      vecs[10] = '{A_TOHOST, 32'h0, 4'h0, 1, 1, 32'h0, 32'h0, 4'h0, 0, 1, 8'h48, 0};
      vecs[11] = '{A_STATUS, 32'h0, 4'h0, 1, 1, 32'h0, 32'h0000_0100, 4'h0, 0, 1, 8'h69, 0};
      vecs[12] = '{A_STATUS, 32'h0, 4'h0, 1, 1, 32'h0, 32'h0, 4'h0, 0, 0, 8'h00, 0};
      vecs[13] = '{A_TOHOST, 32'h0, 4'hF, 0, 1, 32'h0, 32'h0, 4'h0, 0, 0, 8'h00, 0};
      vecs[14] = '{32'hFFFF_0010, 32'h0, 4'h0, 1, 0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 4'h0, 1, 0, 8'h00, 0};
      vecs[15] = '{32'hFFFE_FFFC, 32'h0, 4'h0, 1, 0, 32'h1111_1111, 32'h1111_1111, 4'h0, 1, 0, 8'h00, 0};
      vecs[16] = '{A_CONSOLE, 32'h55, 4'h2, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 8'h00, 0};
      vecs[17] = '{A_STATUS, 32'h0, 4'h0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 8'h00, 0};
      vecs[18] = '{A_TOHOST, 32'h0, 4'h0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0, 8'h00, 0};
      vecs[19] = '{A_CYCLE, 32'h0, 4'h0, 1, 0, 32'h0, 32'd19, 4'h0, 0, 0, 8'h00, 0};

      // ---------------- reset state ----------------
      reset_dut();
      idle(1'b1);
      chk("reset halt", {31'h0, halt}, 32'h0);
      chk("reset timeout", {31'h0, timeout}, 32'h0);
      chk("reset halt_code", halt_code, 32'h0);
      chk("reset con_valid", {31'h0, con_valid}, 32'h0);

      // ---------------- table vectors (basic decode, test 1) ----------------
      reset_dut();
      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re, vecs[i].rdy, vecs[i].mrd);
         chk($sformatf("vec%0d rdata", i), data_rdata, vecs[i].exp_rdata);
         chk($sformatf("vec%0d mem_we", i), {28'h0, mem_we}, {28'h0, vecs[i].exp_mem_we});
         chk($sformatf("vec%0d mem_re", i), {31'h0, mem_re}, {31'h0, vecs[i].exp_mem_re});
         chk($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].addr);
         chk($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].wdata);
         chk($sformatf("vec%0d con_valid", i), {31'h0, con_valid}, {31'h0, vecs[i].exp_cv});
         if (vecs[i].exp_cv)
            chk($sformatf("vec%0d con_data", i), {24'h0, con_data}, {24'h0, vecs[i].exp_cd});
         chk($sformatf("vec%0d halt", i), {31'h0, halt}, {31'h0, vecs[i].exp_halt});
         tick();
      end

      // ---------------- test 2: overflow, push-with-pop when full ----------------
      reset_dut();
      for (int i = 0; i < 17; i++) begin
         drive(A_CONSOLE, 32'h30 + i, 4'h1, 1'b0, 1'b0, 32'h0);
         tick();
      end
      drive(A_STATUS, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
      chk("t2 status full+ovf", data_rdata, 32'h0001_1000);
      tick();
      drive(A_CONSOLE, 32'h50, 4'h1, 1'b0, 1'b1, 32'h0);
      chk("t2 head at full", {24'h0, con_data}, 32'h30);
      tick();
      drive(A_STATUS, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
      chk("t2 status after push+pop", data_rdata, 32'h0001_1000);
      tick();
      for (int i = 0; i < 16; i++) begin
         idle(1'b1);
         chk($sformatf("t2 pop%0d valid", i), {31'h0, con_valid}, 32'h1);
         chk($sformatf("t2 pop%0d data", i), {24'h0, con_data}, (i < 15) ? 32'h31 + i : 32'h50);
         tick();
      end
      drive(A_STATUS, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0);
      chk("t2 empty valid", {31'h0, con_valid}, 32'h0);
      chk("t2 status drained", data_rdata, 32'h0001_0000);
      tick();

      // ---------------- test 3: drain then halt ----------------
      reset_dut();
      for (int i = 0; i < 3; i++) begin
         drive(A_CONSOLE, 32'h41 + i, 4'h1, 1'b0, 1'b0, 32'h0);
         tick();
      end
      drive(A_TOHOST, 32'h1, 4'hF, 1'b0, 1'b0, 32'h0);
      tick();
      drive(A_STATUS, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
      chk("t3 status drain", data_rdata, 32'h0000_0301);
      chk("t3 halt in drain", {31'h0, halt}, 32'h0);
      tick();
      drive(32'h0000_0200, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h0);
      chk("t3 mem_we blocked", {28'h0, mem_we}, 32'h0);
      tick();
      drive(A_CONSOLE, 32'h44, 4'h1, 1'b0, 1'b0, 32'h0);
      tick();
      drive(A_STATUS, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
      chk("t3 console blocked", data_rdata, 32'h0000_0301);
      tick();
      for (int i = 0; i < 3; i++) begin
         idle(1'b1);
         chk($sformatf("t3 pop%0d data", i), {24'h0, con_data}, 32'h41 + i);
         chk($sformatf("t3 pop%0d halt", i), {31'h0, halt}, 32'h0);
         tick();
      end
      idle(1'b1);
      chk("t3 halt after last pop", {31'h0, halt}, 32'h0);
      chk("t3 valid after last pop", {31'h0, con_valid}, 32'h0);
      tick();
      drive(A_TOHOST, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0);
      chk("t3 halt", {31'h0, halt}, 32'h1);
      chk("t3 halt_code", halt_code, 32'h1);
      chk("t3 timeout", {31'h0, timeout}, 32'h0);
      chk("t3 tohost read", data_rdata, 32'h1);
      tick();
      drive(A_STATUS, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0);
      chk("t3 status halted", data_rdata, 32'h0000_0002);
      tick();

      // ---------------- test 4: watchdog ----------------
      reset_dut();
      for (int i = 0; i < 199; i++) begin
         idle(1'b0);
         tick();
      end
      drive(A_CYCLE, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
      chk("t4 cycle 199", data_rdata, 32'd199);
      chk("t4 halt before wd", {31'h0, halt}, 32'h0);
      tick();
      drive(A_CYCLE, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
      chk("t4 halt", {31'h0, halt}, 32'h1);
      chk("t4 timeout", {31'h0, timeout}, 32'h1);
      chk("t4 halt_code", halt_code, 32'hDEAD_0001);
      chk("t4 cycle 200", data_rdata, 32'd200);
      tick();
      drive(A_TOHOST, 32'h77, 4'hF, 1'b0, 1'b0, 32'h0);
      tick();
      drive(32'h0000_0300, 32'h1, 4'hF, 1'b0, 1'b0, 32'h0);
      chk("t4 mem_we halted", {28'h0, mem_we}, 32'h0);
      tick();
      for (int i = 0; i < 5; i++) begin
         idle(1'b0);
         tick();
      end
      drive(A_CYCLE, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
      chk("t4 cycle frozen", data_rdata, 32'd200);
      chk("t4 halt_code kept", halt_code, 32'hDEAD_0001);
      tick();
      drive(A_STATUS, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
      chk("t4 status", data_rdata, 32'h0000_0006);
      tick();

      // ---------------- test 5: tohost on the watchdog cycle ----------------
      reset_dut();
      for (int i = 0; i < 199; i++) begin
         idle(1'b0);
         tick();
      end
      drive(A_TOHOST, 32'h0000_ABCD, 4'hF, 1'b0, 1'b0, 32'h0);
      tick();
      drive(32'h0000_0300, 32'h1234, 4'hF, 1'b0, 1'b0, 32'h0);
      chk("t5 halt in drain", {31'h0, halt}, 32'h0);
      chk("t5 mem_we drain", {28'h0, mem_we}, 32'h0);
      tick();
      idle(1'b0);
      chk("t5 halt", {31'h0, halt}, 32'h1);
      chk("t5 timeout", {31'h0, timeout}, 32'h0);
      chk("t5 halt_code", halt_code, 32'h0000_ABCD);
      tick();

      // ---------------- test 6: reset mid-drain ----------------
      reset_dut();
      for (int i = 0; i < 3; i++) begin
         drive(A_CONSOLE, 32'h61 + i, 4'h1, 1'b0, 1'b0, 32'h0);
         tick();
      end
      drive(A_TOHOST, 32'h5, 4'hF, 1'b0, 1'b0, 32'h0);
      tick();
      drive(A_STATUS, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
      chk("t6 status drain", data_rdata, 32'h0000_0301);
      tick();
      rst = 1'b1;
      idle(1'b0);
      tick();
      rst = 1'b0;
      drive(A_STATUS, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0);
      chk("t6 con_valid", {31'h0, con_valid}, 32'h0);
      chk("t6 status", data_rdata, 32'h0);
      chk("t6 halt_code", halt_code, 32'h0);
      tick();
      drive(A_CYCLE, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0);
      chk("t6 cycle", data_rdata, 32'd1);
      chk("t6 con_valid later", {31'h0, con_valid}, 32'h0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
